// File: rtl/explosion_pkg.sv
// explosion_pkg: sprite geometry defaults, palette constants and FSM state types
package explosion_pkg;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;
  localparam int NFRAMES = 3;
  localparam int FRAME_HOLD = 8;
  localparam int ADDR_W = 12;
  localparam logic [7:0] TRANSPARENT = 8'h00;
  typedef enum logic {OFF, PLAY} anim_state_t;
  typedef enum logic [1:0] {F_IDLE, F_READ, F_DRAIN} fetch_state_t;
endpackage

// File: rtl/explosion_line_buffer.sv
// explosion_line_buffer: one sprite row of palette indices, sync write, async read
module explosion_line_buffer #(
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  // cleared on reset so a half-fetched row can never reach the screen
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/explosion_sprite_reader.sv
// explosion_sprite_reader: animation sequencer, hblank row fetch and pixel stream; EXPLOSION_SCALE2X_EN draws at 2x
module explosion_sprite_reader
  import explosion_pkg::*;
#(
  parameter int         SPRITE_W    = explosion_pkg::SPRITE_W,
  parameter int         SPRITE_H    = explosion_pkg::SPRITE_H,
  parameter int         NFRAMES     = explosion_pkg::NFRAMES,
  parameter int         FRAME_HOLD  = explosion_pkg::FRAME_HOLD,
  parameter logic [7:0] TRANSPARENT = explosion_pkg::TRANSPARENT,
  parameter int         ADDR_W      = explosion_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trigger,
  input  logic [9:0]        trig_x,
  input  logic [9:0]        trig_y,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [9:0]        line_y,
  input  logic [9:0]        hcount,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_clken,
  input  logic [7:0]        rom_readdata,
  output logic [7:0]        pix_index,
  output logic              pix_valid,
  output logic              active,
  output logic              done
);
  localparam int CW = $clog2(SPRITE_W);
  localparam int FW = $clog2(NFRAMES + 1);
  localparam int HW = $clog2(FRAME_HOLD + 1);
  anim_state_t anim_q, anim_d;
  fetch_state_t fs_q, fs_d;
  logic [9:0] x0_q, x0_d, y0_q, y0_d, dy, dx, row;
  logic [FW-1:0] frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic done_q, done_d, line_hit_q, line_hit_d, wr_en_q, row_hit, in_x;
  logic [CW-1:0] col_q, col_d, wr_col_q, col_rd;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0] rd, pix_index_q;
  logic pix_valid_q;
  assign dy = line_y - y0_q;
  assign dx = hcount - x0_q;
`ifdef EXPLOSION_SCALE2X_EN
  assign row_hit = dy < 10'(2 * SPRITE_H);
  assign row = dy >> 1;
  assign in_x = dx < 10'(2 * SPRITE_W);
  assign col_rd = CW'(dx >> 1);
`else
  assign row_hit = dy < 10'(SPRITE_H);
  assign row = dy;
  assign in_x = dx < 10'(SPRITE_W);
  assign col_rd = CW'(dx);
`endif
  // animation: trigger restarts, frame_start steps hold/frame, done pulses as play ends
  always_comb begin
    anim_d = anim_q;
    x0_d = x0_q;
    y0_d = y0_q;
    frame_d = frame_q;
    hold_d = hold_q;
    done_d = 1'b0;
    if (trigger) begin
      anim_d = PLAY;
      x0_d = trig_x;
      y0_d = trig_y;
      frame_d = '0;
      hold_d = '0;
    end else if (anim_q == PLAY && frame_start) begin
      hold_d = (hold_q == HW'(FRAME_HOLD - 1)) ? '0 : hold_q + 1'b1;
      if (hold_q == HW'(FRAME_HOLD - 1)) begin
        frame_d = frame_q + 1'b1;
        if (frame_q == FW'(NFRAMES - 1)) begin
          anim_d = OFF;
          frame_d = '0;
          done_d = 1'b1;
        end
      end
    end
  end
  // fetch: any line_start aborts; a hit restarts at col 0, column counter freezes when idle so the address holds
  always_comb begin
    fs_d = fs_q;
    col_d = col_q;
    base_d = base_q;
    line_hit_d = line_hit_q;
    if (trigger) begin
      fs_d = F_IDLE;
      line_hit_d = 1'b0;
    end else if (line_start) begin
      line_hit_d = anim_q == PLAY && row_hit;
      fs_d = line_hit_d ? F_READ : F_IDLE;
      if (line_hit_d) begin
        col_d = '0;
        base_d = ADDR_W'(int'(frame_q) * SPRITE_W * SPRITE_H + int'(row) * SPRITE_W);
      end
    end else if (fs_q == F_READ) begin
      fs_d = (col_q == CW'(SPRITE_W - 1)) ? F_DRAIN : F_READ;
      col_d = (col_q == CW'(SPRITE_W - 1)) ? col_q : col_q + 1'b1;
    end else if (fs_q == F_DRAIN) begin
      fs_d = F_IDLE;
    end
  end
  // state registers; the write lags the address by one cycle to meet ROM latency
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      anim_q <= OFF;
      fs_q <= F_IDLE;
      x0_q <= '0;
      y0_q <= '0;
      frame_q <= '0;
      hold_q <= '0;
      done_q <= 1'b0;
      line_hit_q <= 1'b0;
      col_q <= '0;
      base_q <= '0;
      wr_en_q <= 1'b0;
      wr_col_q <= '0;
    end else begin
      anim_q <= anim_d;
      fs_q <= fs_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      frame_q <= frame_d;
      hold_q <= hold_d;
      done_q <= done_d;
      line_hit_q <= line_hit_d;
      col_q <= col_d;
      base_q <= base_d;
      wr_en_q <= fs_q == F_READ && !trigger && !line_start;
      wr_col_q <= col_q;
    end
  explosion_line_buffer #(.DEPTH(SPRITE_W)) u_buf (
    .clk(clk),
    .reset_n(reset_n),
    .we_i(wr_en_q),
    .waddr_i(wr_col_q),
    .wdata_i(rom_readdata),
    .raddr_i(col_rd),
    .rdata_o(rd)
  );
  // pixel stage: registered one cycle behind hcount
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_index_q <= in_x ? rd : '0;
      pix_valid_q <= line_hit_q && in_x && rd != TRANSPARENT;
    end
  assign rom_address = base_q + ADDR_W'(col_q);
  assign rom_chipselect = fs_q == F_READ;
  assign rom_clken = fs_q == F_READ;
  assign pix_index = pix_index_q;
  assign pix_valid = pix_valid_q;
  assign active = anim_q == PLAY;
  assign done = done_q;
endmodule

// File: tb/tb_explosion_sprite_reader.sv
// tb_explosion_sprite_reader: directed plan checks plus randomized run against a behavioural model
module tb_explosion_sprite_reader;
`ifdef EXPLOSION_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif
  localparam int FH = 8;
  localparam int NF = 3;
  localparam int ROW52 = 2 / SC;
  localparam int ROW60 = 10 / SC;
  localparam int YMISS = 50 + 32 * SC;
  localparam int SPAN = 32 * SC;
  logic clk = 1'b0, reset_n = 1'b0;
  logic trigger = 1'b0, frame_start = 1'b0, line_start = 1'b0;
  logic [9:0] trig_x = '0, trig_y = '0, line_y = '0, hcount = '0;
  logic [11:0] rom_address;
  logic rom_chipselect, rom_clken, pix_valid, active, done;
  logic [7:0] rom_readdata = '0, pix_index;
  logic [7:0] rom [3072];
  int n_checks = 0, n_fail = 0;
  logic m_play, m_lhit, e_done, e_pv;
  logic [9:0] m_x0, m_y0, t_d, t_r;
  logic [7:0] m_buf [32];
  logic [7:0] e_pi;
  int m_nfs, m_ft, m_base, m_last, t_frame;
  bit m_buf_ok, pi_ok, pv_ok, t_inr, t_hit, t_play;
  int r_x, r_y, gap;
  explosion_sprite_reader dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .trig_x(trig_x), .trig_y(trig_y),
    .frame_start(frame_start), .line_start(line_start), .line_y(line_y), .hcount(hcount),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_clken(rom_clken),
    .rom_readdata(rom_readdata), .pix_index(pix_index), .pix_valid(pix_valid),
    .active(active), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rom_chipselect && rom_clken) rom_readdata <= rom[rom_address];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int lit_index(input int k);
    int j;
    if (k < 0 || k >= SPAN) return 0;
    j = k / SC;
    return (j == 5) ? 0 : j + 1;
  endfunction
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_play = 0; m_x0 = '0; m_y0 = '0; m_nfs = 0; m_lhit = 0; m_ft = 0; m_base = 0; m_last = 0;
      m_buf_ok = 1; e_done = 0; e_pi = '0; e_pv = 0; pi_ok = 1; pv_ok = 1;
      for (int k = 0; k < 32; k++) m_buf[k] = '0;
    end else begin
      t_d = hcount - m_x0;
      t_inr = int'(t_d) < SPAN;
      e_pi = t_inr ? m_buf[int'(t_d) / SC] : 8'h00;
      e_pv = m_lhit && t_inr && e_pi != 8'h00;
      pi_ok = !t_inr || m_buf_ok;
      pv_ok = !t_inr || !m_lhit || m_buf_ok;
      e_done = 0;
      t_play = m_play;
      t_frame = m_nfs / FH;
      if (m_ft == 33) begin
        for (int k = 0; k < 32; k++) m_buf[k] = rom[m_base + k];
        m_buf_ok = 1;
        m_ft = 0;
      end else if (m_ft > 0) m_ft++;
      if (trigger) begin
        m_play = 1; m_x0 = trig_x; m_y0 = trig_y; m_nfs = 0; m_lhit = 0; m_ft = 0;
      end else begin
        if (m_play && frame_start) begin
          m_nfs++;
          if (m_nfs == NF * FH) begin m_play = 0; e_done = 1; end
        end
        if (line_start) begin
          m_ft = 0;
          t_r = line_y - m_y0;
          t_hit = t_play && int'(t_r) < 32 * SC;
          m_lhit = t_hit;
          if (t_hit) begin
            m_base = t_frame * 1024 + (int'(t_r) / SC) * 32;
            m_ft = 1;
            m_buf_ok = 0;
          end
        end
      end
      if (m_ft >= 1 && m_ft <= 32) m_last = m_base + m_ft - 1;
    end
    #2;
    chk("active", 32'(active), 32'(m_play));
    chk("done", 32'(done), 32'(e_done));
    chk("rom_cs", 32'(rom_chipselect), 32'(m_ft >= 1 && m_ft <= 32));
    chk("rom_clken", 32'(rom_clken), 32'(m_ft >= 1 && m_ft <= 32));
    chk("rom_addr", 32'(rom_address), 32'(m_last));
    if (pv_ok) chk("pix_valid", 32'(pix_valid), 32'(e_pv));
    if (pi_ok) chk("pix_index", 32'(pix_index), 32'(e_pi));
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_trig(input int x, input int y);
    trig_x = 10'(x); trig_y = 10'(y); trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask
  task automatic pulse_ls(input int y);
    line_y = 10'(y); line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask
  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 3072; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int j = 0; j < 32; j++) rom[ROW52 * 32 + j] = 8'((j == 5) ? 0 : j + 1);
    cyc(3);
    chk("rst_active", 32'(active), 0);
    chk("rst_cs", 32'(rom_chipselect), 0);
    chk("rst_addr", 32'(rom_address), 0);
    chk("rst_pix", 32'({pix_valid, pix_index, done}), 0);
    reset_n = 1'b1;
    cyc(2);
    pulse_trig(100, 50);
    pulse_ls(52);
    chk("fetch_first_addr", 32'(rom_address), ROW52 * 32);
    chk("fetch_first_cs", 32'(rom_chipselect), 1);
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      chk("fetch_addr", 32'(rom_address), ROW52 * 32 + k);
    end
    chk("fetch_last_cs", 32'(rom_chipselect), 1);
    @(negedge clk);
    chk("fetch_drain_cs", 32'(rom_chipselect), 0);
    @(negedge clk);
    chk("fetch_idle_cs", 32'(rom_chipselect), 0);
    cyc(3);
    for (int h = 99; h <= 100 + SPAN; h++) begin
      hcount = 10'(h);
      @(negedge clk);
      chk("sweep_index", 32'(pix_index), lit_index(h - 100));
      chk("sweep_valid", 32'(pix_valid), 32'(lit_index(h - 100) != 0));
    end
    hcount = '0;
    repeat (8) pulse_fs();
    pulse_ls(50);
    chk("frame1_addr", 32'(rom_address), 1024);
    cyc(40);
    repeat (15) pulse_fs();
    chk("pre_end_active", 32'(active), 1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("end_done", 32'(done), 1);
    chk("end_active", 32'(active), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    pulse_ls(52);
    chk("off_no_read", 32'(rom_chipselect), 0);
    cyc(2);
    chk("off_no_read2", 32'(rom_chipselect), 0);
    pulse_trig(100, 50);
    cyc(2);
    pulse_ls(49);
    chk("miss_above_cs", 32'(rom_chipselect), 0);
    hcount = 10'd110;
    cyc(2);
    chk("miss_above_pix", 32'(pix_valid), 0);
    pulse_ls(YMISS);
    chk("miss_below_cs", 32'(rom_chipselect), 0);
    cyc(2);
    chk("miss_below_pix", 32'(pix_valid), 0);
    pulse_ls(52);
    cyc(8);
    chk("abort_pre_addr", 32'(rom_address), ROW52 * 32 + 8);
    pulse_ls(60);
    chk("abort_restart_addr", 32'(rom_address), ROW60 * 32);
    chk("abort_restart_cs", 32'(rom_chipselect), 1);
    cyc(40);
    repeat (7) pulse_fs();
    trig_x = 10'd100; trig_y = 10'd50; trigger = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    trigger = 1'b0; frame_start = 1'b0;
    cyc(2);
    pulse_ls(50);
    chk("trig_wins_addr", 32'(rom_address), 0);
    cyc(40);
    pulse_ls(52);
    cyc(5);
    reset_n = 1'b0;
    #1;
    chk("midrst_cs", 32'(rom_chipselect), 0);
    chk("midrst_active", 32'(active), 0);
    chk("midrst_addr", 32'(rom_address), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);
    chk("midrst_pix", 32'(pix_valid), 0);
    r_x = 0; r_y = 0; gap = 5;
    for (int i = 0; i < 8000; i++) begin
      trigger = (i == 0) || ($urandom_range(0, 699) == 0);
      if (trigger) begin
        r_x = int'($urandom_range(0, 600));
        r_y = int'($urandom_range(0, 400));
        trig_x = 10'(r_x);
        trig_y = 10'(r_y);
      end
      frame_start = $urandom_range(0, 24) == 0;
      gap--;
      line_start = 1'b0;
      if (gap <= 0) begin
        line_start = 1'b1;
        line_y = 10'(r_y + int'($urandom_range(0, 32 * SC + 8)) - 4);
        gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 30)) : int'($urandom_range(34, 60));
      end
      hcount = 10'(r_x + int'($urandom_range(0, SPAN + 8)) - 3);
      @(negedge clk);
    end
    trigger = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
